// File: rtl/e1_wb_rx_pkg.sv
// Shared E1 RX bus-side definitions: register bit positions and mode encoding.
// The CSR layout and BD port layout are shared with the TX bus block.
package e1_wb_rx_pkg;

  localparam int unsigned BUS_W = 16;

  // CSR write fields
  localparam int unsigned CSR_ENABLE    = 0;
  localparam int unsigned CSR_MODE_LSB  = 1;
  localparam int unsigned CSR_CLEAR     = 12;

  // CSR read fields
  localparam int unsigned CSR_ALIGNED   = 7;
  localparam int unsigned CSR_BDI_EMPTY = 8;
  localparam int unsigned CSR_BDI_FULL  = 9;
  localparam int unsigned CSR_BDO_EMPTY = 10;
  localparam int unsigned CSR_BDO_FULL  = 11;
  localparam int unsigned CSR_OVERFLOW  = 12;
  localparam int unsigned CSR_ALIGN_ERR = 13;

  // BD port read fields
  localparam int unsigned BD_CRC_LSB    = 13;
  localparam int unsigned BD_VALID      = 15;

  typedef enum logic [1:0] {
    MODE_RAW       = 2'b00,
    MODE_FRAMED    = 2'b01,
    MODE_CRC4      = 2'b10,
    MODE_CRC4_AUTO = 2'b11
  } rx_mode_e;

endpackage

// File: rtl/fifo_sync_shift.sv
// Synchronous shift-register FIFO; head is always at slot 0.
// Ports: clk/rst_n, push_i/data_i write side, pop_i/data_o read side,
//        empty_o/full_o registered status flags.
// Push while full and pop while empty are ignored.
module fifo_sync_shift #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d, wr_idx;
  logic             empty_q, full_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Shift down on pop; the write slot follows the post-pop fill level.
  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    wr_idx = cnt_q;
    if (do_pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = '0;
      cnt_d  = cnt_q - CW'(1);
      wr_idx = cnt_q - CW'(1);
    end
    if (do_push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) mem_d[i] = data_i;
      end
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CW'(DEPTH));
    end
  end

  assign data_o  = mem_q[0];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/e1_wb_rx.sv
// E1 RX bus-side controller: RX CSRs, BD-in/BD-out descriptor FIFOs, core
// control, sticky overflow/align error flags and the auto CRC E-bit report.
// Ports: bus_* decoded bus strobes and data (rdata is 0 when not selected);
//        ctrl_* e1_rx core control; bdrx_* core slot handshake;
//        status_aligned core alignment; rx_crc_e_auto/ack to TX; irq.
module e1_wb_rx
  import e1_wb_rx_pkg::*;
#(
  parameter int unsigned MFW      = 7,
  parameter int unsigned BD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_addr_sel,
  input  logic             bus_addr_lsb,
  input  logic [BUS_W-1:0] bus_wdata,
  output logic [BUS_W-1:0] bus_rdata,
  input  logic             bus_clr,
  input  logic             bus_we,
  output logic             ctrl_rst,
  output logic [1:0]       ctrl_mode,
  output logic [MFW-1:0]   bdrx_mf,
  output logic             bdrx_valid,
  input  logic             bdrx_done,
  input  logic [1:0]       bdrx_crc_e,
  input  logic             bdrx_miss,
  input  logic             status_aligned,
  output logic [1:0]       rx_crc_e_auto,
  input  logic             rx_crc_e_ack,
  output logic             irq
);

  localparam int unsigned BDO_W = MFW + 2;

  logic             csr_we_q, bd_we_q, bd_re_q;
  logic [BUS_W-1:0] wdata_q;
  logic             enable_q, enable_d;
  rx_mode_e         mode_q, mode_d;
  logic             overflow_q, overflow_d;
  logic             align_err_q, align_err_d;
  logic             aligned_q;
  logic             ctrl_rst_q;
  logic [1:0]       crc_auto_q, crc_auto_d;
  logic             csr_clr;

  logic             bdi_push, bdi_empty, bdi_full;
  logic [MFW-1:0]   bdi_dout;
  logic             bdo_push, bdo_pop, bdo_empty, bdo_full;
  logic [BDO_W-1:0] bdo_dout;

  logic [BUS_W-1:0] csr_rdata, bd_rdata;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_q;

  // Slots submitted by software; the core consumes the head on done.
  fifo_sync_shift #(.WIDTH(MFW), .DEPTH(BD_DEPTH)) u_bdi (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (bdi_push),
    .data_i (wdata_q[MFW-1:0]),
    .pop_i  (bdrx_done),
    .data_o (bdi_dout),
    .empty_o(bdi_empty),
    .full_o (bdi_full)
  );

  // Filled slots returned to software with their CRC error flags.
  fifo_sync_shift #(.WIDTH(BDO_W), .DEPTH(BD_DEPTH)) u_bdo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (bdo_push),
    .data_i ({bdrx_crc_e, bdi_dout}),
    .pop_i  (bdo_pop),
    .data_o (bdo_dout),
    .empty_o(bdo_empty),
    .full_o (bdo_full)
  );

  assign bdi_push = bd_we_q & ~bdi_full;
  assign bdo_push = bdrx_done & ~bdo_full;
  assign bdo_pop  = bd_re_q & ~bdo_empty;
  assign csr_clr  = csr_we_q & wdata_q[CSR_CLEAR];

  // Next-state for CSRs and sticky flags; sets dominate the clear pulse.
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    if (csr_we_q) begin
      enable_d = wdata_q[CSR_ENABLE];
      mode_d   = rx_mode_e'(wdata_q[CSR_MODE_LSB +: 2]);
    end
    overflow_d  = (overflow_q & ~csr_clr) | bdrx_miss | (bdrx_done & bdo_full);
    align_err_d = (align_err_q & ~csr_clr) | (aligned_q & ~status_aligned & enable_q);
    crc_auto_d  = rx_crc_e_ack ? 2'b00 : crc_auto_q;
    if (bdrx_done && (mode_q == MODE_CRC4_AUTO)) begin
      crc_auto_d = crc_auto_d | bdrx_crc_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_we_q    <= 1'b0;
      bd_we_q     <= 1'b0;
      bd_re_q     <= 1'b0;
      wdata_q     <= '0;
      enable_q    <= 1'b0;
      mode_q      <= MODE_RAW;
      overflow_q  <= 1'b0;
      align_err_q <= 1'b0;
      aligned_q   <= 1'b0;
      ctrl_rst_q  <= 1'b1;
      crc_auto_q  <= 2'b00;
    end else begin
      csr_we_q    <= bus_we & bus_addr_sel & ~bus_addr_lsb & ~bus_clr;
      bd_we_q     <= bus_we & bus_addr_sel & bus_addr_lsb & ~bus_clr;
      bd_re_q     <= ~bus_we & bus_addr_sel & bus_addr_lsb & ~bus_clr;
      wdata_q     <= bus_wdata;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      overflow_q  <= overflow_d;
      align_err_q <= align_err_d;
      aligned_q   <= status_aligned;
      ctrl_rst_q  <= ~enable_q;
      crc_auto_q  <= crc_auto_d;
    end
  end

  // Combinational read mux over CSR and BD-out head.
  always_comb begin
    csr_rdata                       = '0;
    csr_rdata[CSR_ENABLE]           = enable_q;
    csr_rdata[CSR_MODE_LSB +: 2]    = mode_q;
    csr_rdata[CSR_ALIGNED]          = status_aligned;
    csr_rdata[CSR_BDI_EMPTY]        = bdi_empty;
    csr_rdata[CSR_BDI_FULL]         = bdi_full;
    csr_rdata[CSR_BDO_EMPTY]        = bdo_empty;
    csr_rdata[CSR_BDO_FULL]         = bdo_full;
    csr_rdata[CSR_OVERFLOW]         = overflow_q;
    csr_rdata[CSR_ALIGN_ERR]        = align_err_q;
    bd_rdata                        = '0;
    bd_rdata[BD_VALID]              = ~bdo_empty;
    bd_rdata[BD_CRC_LSB +: 2]       = bdo_dout[MFW +: 2];
    bd_rdata[MFW-1:0]               = bdo_dout[MFW-1:0];
    bus_rdata                       = '0;
    if (bus_addr_sel) bus_rdata = bus_addr_lsb ? bd_rdata : csr_rdata;
  end

  assign ctrl_rst      = ctrl_rst_q;
  assign ctrl_mode     = mode_q;
  assign bdrx_mf       = bdi_dout;
  assign bdrx_valid    = ~bdi_empty;
  assign rx_crc_e_auto = crc_auto_q;
  assign irq           = ~bdo_empty | overflow_q | align_err_q;

endmodule

// File: doc/e1_wb_rx.md
Name: e1_wb_rx

Overview:
E1 RX bus-side controller. It owns the RX control/status CSRs and the two RX buffer-descriptor (BD) FIFOs: empty multiframe slots submitted by software, and filled multiframes returned to software. It drives the control inputs of the e1_rx core, consumes that core's BD handshake, and tracks overflow and alignment loss. It also generates the auto CRC E-bit report consumed by the TX side. It sits inside the top-level E1 wishbone wrapper, next to the TX bus-side controller, and shares the same decoded bus strobes.

Parameters:
MFW, 7, multiframe index width (buffer holds 2^MFW multiframes)
BD_DEPTH, 4, depth of each BD FIFO

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bus_addr_sel  in  1  this block selected
bus_addr_lsb  in  1  0 = CSR, 1 = BD port
bus_wdata  in  16  write data
bus_rdata  out  16  read data, 0 when not selected
bus_clr  in  1  end-of-access clear
bus_we  in  1  write strobe
ctrl_rst  out  1  e1_rx core local reset
ctrl_mode  out  2  00 raw, 01 framed, 1x framed+CRC4
bdrx_mf  out  MFW  multiframe slot offered to core
bdrx_valid  out  1  slot available
bdrx_done  in  1  core finished the current slot (1-cycle pulse)
bdrx_crc_e  in  2  CRC error flags of the 2 sub-multiframes, valid with done
bdrx_miss  in  1  core needed a slot and none was valid
status_aligned  in  1  core frame alignment state
rx_crc_e_auto  out  2  accumulated CRC errors for TX E-bits
rx_crc_e_ack  in  1  TX consumed rx_crc_e_auto
irq  out  1  interrupt request

Behaviour:
- Reset (rst_n low, asynchronous): enable=0, mode=00, ctrl_rst=1, overflow=0, align_err=0, rx_crc_e_auto=00, both FIFOs empty, irq=0, bdrx_valid=0.
- Write path:
  - The CSR write enable is registered from bus_we & sel & lsb==0, and is forced to 0 while bus_clr is high or bus_we is low.
  - Registers update 1 cycle after the write is accepted: wdata[0] sets enable, wdata[2:1] sets mode.
  - wdata[12]=1 is a clear pulse for overflow and align_err, taken in the same cycle.
- CSR read (combinational): [12] overflow, [11] bdo_full, [10] bdo_empty, [9] bdi_full, [8] bdi_empty, [2:1] mode, [1] is replaced by nothing; the exact layout is [13] align_err, [12:8] as listed above, [7] status_aligned, [2:1] mode, [0] enable, all other bits 0.
- BD port write: pushes wdata[MFW-1:0] into BD-in. The push is registered and masked with ~bdi_full. A write while full is dropped silently.
- BD port read: returns {~bdo_empty, bdo_crc_e[1:0], zeros, bdo_mf}. The pop is registered (asserted the cycle after the read strobe), masked with ~bdo_empty, and cleared by bus_clr. A read while empty returns bit15=0 and pops nothing.
- Core interface:
  - bdrx_mf is the head of BD-in; bdrx_valid = ~bdi_empty.
  - On bdrx_done: pop BD-in, and push {crc_e, mf} into BD-out if it is not full.
  - If BD-out is full on done, the descriptor is lost and overflow is set.
- Overflow (sticky): set by bdrx_miss or by done while BD-out is full. Cleared by the CSR clear pulse. If set and clear occur in the same cycle, set wins.
- align_err (sticky): set on a 1->0 edge of status_aligned while enable=1. The edge is detected using a registered copy of status_aligned, which is reset to 0. Cleared by the CSR clear pulse; set wins over clear.
- ctrl_rst: registered ~enable, so the core leaves reset 1 cycle after enable is written. Disabling puts the core back into reset; FIFO contents and sticky flags are retained.
- rx_crc_e_auto:
  - On done, when mode==11, OR bdrx_crc_e into the register.
  - On rx_crc_e_ack, clear it. If ack and done coincide, the result is the new crc_e alone.
  - In other modes, done does not update it.
- irq = ~bdo_empty | overflow | align_err (combinational from registers).

Decomposition:
- Register bit positions (enable, mode, clear = 12, status bits, BD valid = 15, crc_e = 14:13) go in the shared E1 register-definition include used by the TX and RX bus blocks.
- Both FIFOs are instances of the existing fifo_sync_shift: BD-in is MFW wide, BD-out is MFW+2 wide.
- No other sub-module.

Test Plan:
- Reset, then read CSR and BD port -> CSR = 0x0500 (both FIFOs empty), BD read = 0x0000, irq=0, ctrl_rst=1.
- Write CSR 0x0005, then push mf 3 and mf 4 -> ctrl_rst=0 one cycle after the write, mode=10, bdrx_valid=1, bdrx_mf=3. After a done pulse with crc_e=01, bdrx_mf=4, irq=1, and the BD read returns 0xA003 (bit15, crc_e=01, mf 3), after which bdo_empty=1.
- Fill BD-out with 4 done pulses without reading, then issue a 5th done -> overflow=1 and the 5th descriptor is absent. A CSR write 0x1005 clears overflow. Asserting bdrx_miss in the same cycle as the clear leaves overflow=1.
- Mode 11: done with crc_e=01, then done with crc_e=10 -> rx_crc_e_auto=11. ack alone gives 00. ack coinciding with done crc_e=10 gives 10.
- Enable=1 with status_aligned 1->0 -> align_err=1 and irq=1. The same edge with enable=0 leaves align_err=0.
- Push 5 BDs, then drive rst_n low mid-transfer -> the 5th push is dropped with bdi_full=1; reset asynchronously restores every output to its reset value.
